cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The module SHALL have a single clock, i_clk, with one clock input, 1 bit, all state updating on its rising edge.
REQ-002 The module SHALL have i_reset, an input, 1 bit, asynchronous and active-high.
REQ-003 i_data SHALL be an input, 8 bits: the external data pins, sampled only at the end of WAIT_OP.
REQ-004 i_rdy SHALL be an input, 1 bit: 1 = run, 0 = freeze.
REQ-005 o_ctrl SHALL be an output, 36 bits: one datapath control strobe per bit, with the bit map taken from the package; bit 0 = rw, where 1 = read.
REQ-006 o_sync SHALL be an output, 1 bit: high during FETCH.
REQ-007 o_jam SHALL be an output, 1 bit: high while the sequencer is halted on an unsupported opcode.
REQ-008 o_state SHALL be an output, 4 bits: the current state encoding, for debug.

Function
REQ-009 Timing contract: strobes asserted in state S drive the internal busses during S.
- adl_abl/adh_abh load the address register at the end of S.
- The read data is latched by DL at the end of S+1.
- DL is valid during S+2.
REQ-010 "Idle word" SHALL mean rw=1 with every other o_ctrl bit 0.
REQ-011 The reset sequence SHALL be R0 -> R1 -> V0 -> V1 -> V2 -> V3 -> FETCH, one cycle each.
- R0, R1: idle word.
- V0: 0_adl0, 0_adl1, adl_abl, adh_abh (address FFFC; ADH undriven reads FF).
- V1: 0_adl1, adl_abl (address FFFD).
- V2: dl_adl, adl_pcl.
- V3: dl_adh, adh_pch.
REQ-012 FETCH SHALL assert pcl_adl, pch_adh, adl_abl, adh_abh, i_pc, pcl_pcl, pch_pch and o_sync, then go to WAIT_OP.
REQ-013 WAIT_OP SHALL output the idle word, load IR from i_data at its end, and select the next state from i_data.
REQ-014 The next state after WAIT_OP SHALL be:
- EA -> FETCH.
- AA, A8, 8A, 98 -> XFER.
- A9, A2, A0 -> OPR.
- 4C -> J0.
- any other value -> JAM.
REQ-015 XFER SHALL drive src_sb plus sb_dst, then go to FETCH:
- TAX: ac_sb + sb_x.
- TAY: ac_sb + sb_y.
- TXA: x_sb + sb_ac.
- TYA: y_sb + sb_ac.
REQ-016 The immediate-load states SHALL run OPR -> OPR_WAIT -> OPR_LOAD -> FETCH.
- OPR: same strobes as FETCH, without o_sync.
- OPR_WAIT: idle word.
- OPR_LOAD: dl_db, sb_db, plus sb_ac, sb_x or sb_y per IR.
REQ-017 The JMP absolute states SHALL run J0 -> J1 -> J2 -> J3 -> FETCH.
- J0 and J1: the OPR strobe set.
- J2: dl_adl, adl_pcl.
- J3: dl_adh, adh_pch.
REQ-018 JAM SHALL output the idle word with o_jam=1 and hold until reset.
REQ-019 When i_rdy=0 during a clock edge, state and IR SHALL hold.
- While i_rdy=0, o_ctrl SHALL be the idle word and o_sync SHALL be 0.
- Execution SHALL resume in the held state on the first cycle with i_rdy=1.
REQ-020 i_rdy SHALL be ignored in R0, R1 and JAM.
REQ-021 o_ctrl, o_sync and o_jam SHALL be combinational decodes of the registered state and IR plus i_rdy, with no further registering.

Reset
REQ-022 While i_reset=1, all registers SHALL be at their reset values:
- state = R0, IR = EA.
- o_ctrl = idle word, o_sync = 0, o_jam = 0.
REQ-023 Asserting i_reset in any state, including mid-instruction and JAM, SHALL reach these values immediately without waiting for a clock edge.
REQ-024 The first rising edge after reset deassertion SHALL move R0 -> R1.

Structure
REQ-025 The shared package cpu_ctrl_pkg SHALL hold:
- the CTRL_* bit index constants, with width 36;
- the state enumeration;
- the supported opcode constants.
REQ-026 Exactly one sub-module, ctrl_encoder, SHALL exist: purely combinational, mapping state, IR and i_rdy to o_ctrl, o_sync and o_jam.
REQ-027 The next-state register and the IR SHALL reside in cpu_sequencer.

Verification
REQ-028 Reset release: the first FETCH SHALL occur in cycle 7 after the deassert edge. With FFFC=00 and FFFD=80 in the integrated core, o_address SHALL equal 8000 in cycle 8.
REQ-029 LDA #$42 (A9 42): the sequence SHALL be FETCH, WAIT_OP, OPR, OPR_WAIT, OPR_LOAD (5 cycles). OPR_LOAD SHALL show dl_db, sb_db and sb_ac only, and the integrated AC SHALL equal 42.
REQ-030 JMP $1234 (4C 34 12): the sequence SHALL be 6 cycles, and the next FETCH SHALL drive address 1234.
REQ-031 Opcode 02 SHALL give o_jam=1 with the idle word held for 20 cycles; a subsequent reset pulse SHALL clear o_jam and restart at R0.
REQ-032 i_rdy=0 for 3 cycles in OPR_WAIT: the state SHALL hold, o_ctrl SHALL stay the idle word, and OPR_LOAD SHALL follow on the first i_rdy=1 cycle.
REQ-033 i_reset asserted mid-cycle in J2: o_state SHALL be R0 and o_ctrl the idle word before the next clock edge, and the reset sequence SHALL then repeat exactly.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcoded CPU sequencer: control-word bit map,
// state encoding and the supported opcodes.
package cpu_ctrl_pkg;

  localparam int unsigned CTRL_W = 36;

  localparam int unsigned CTRL_RW         = 0;
  localparam int unsigned CTRL_ADL_ABL    = 1;
  localparam int unsigned CTRL_ADH_ABH    = 2;
  localparam int unsigned CTRL_ZERO_ADL0  = 3;
  localparam int unsigned CTRL_ZERO_ADL1  = 4;
  localparam int unsigned CTRL_ZERO_ADL2  = 5;
  localparam int unsigned CTRL_DL_ADL     = 6;
  localparam int unsigned CTRL_DL_ADH     = 7;
  localparam int unsigned CTRL_DL_DB      = 8;
  localparam int unsigned CTRL_ADL_PCL    = 9;
  localparam int unsigned CTRL_ADH_PCH    = 10;
  localparam int unsigned CTRL_PCL_ADL    = 11;
  localparam int unsigned CTRL_PCH_ADH    = 12;
  localparam int unsigned CTRL_I_PC       = 13;
  localparam int unsigned CTRL_PCL_PCL    = 14;
  localparam int unsigned CTRL_PCH_PCH    = 15;
  localparam int unsigned CTRL_AC_SB      = 16;
  localparam int unsigned CTRL_X_SB       = 17;
  localparam int unsigned CTRL_Y_SB       = 18;
  localparam int unsigned CTRL_SB_AC      = 19;
  localparam int unsigned CTRL_SB_X       = 20;
  localparam int unsigned CTRL_SB_Y       = 21;
  localparam int unsigned CTRL_SB_DB      = 22;
  localparam int unsigned CTRL_S_ADL      = 23;
  localparam int unsigned CTRL_S_SB       = 24;
  localparam int unsigned CTRL_SB_S       = 25;
  localparam int unsigned CTRL_ADD_ADL    = 26;
  localparam int unsigned CTRL_ADD_SB     = 27;
  localparam int unsigned CTRL_ADH_SB     = 28;
  localparam int unsigned CTRL_SB_ADH     = 29;
  localparam int unsigned CTRL_ZERO_ADH0  = 30;
  localparam int unsigned CTRL_ZERO_ADH17 = 31;
  localparam int unsigned CTRL_DB_ADD     = 32;
  localparam int unsigned CTRL_SB_ADD     = 33;
  localparam int unsigned CTRL_AC_DB      = 34;
  localparam int unsigned CTRL_P_DB       = 35;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 36'h0_0000_0001;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;

  // Vector-load and JMP operand-load cycles are identical (same strobes, same
  // successor), so V2/J2 share StPcl and V3/J3 share StPch.
  typedef enum logic [3:0] {
    StR0      = 4'd0,
    StR1      = 4'd1,
    StV0      = 4'd2,
    StV1      = 4'd3,
    StPcl     = 4'd4,
    StPch     = 4'd5,
    StFetch   = 4'd6,
    StWaitOp  = 4'd7,
    StXfer    = 4'd8,
    StOpr     = 4'd9,
    StOprWait = 4'd10,
    StOprLoad = 4'd11,
    StJ0      = 4'd12,
    StJ1      = 4'd13,
    StJam     = 4'd14
  } state_e;

  function automatic state_e op_to_state(input logic [7:0] op);
    case (op)
      OP_NOP:                             return StFetch;
      OP_TAX, OP_TAY, OP_TXA, OP_TYA:     return StXfer;
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: return StOpr;
      OP_JMP_ABS:                         return StJ0;
      default:                            return StJam;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-side bus: opcode data and ready in, control word and status out.
interface cpu_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [7:0]        i_data;
  logic              i_rdy;
  logic [CTRL_W-1:0] o_ctrl;
  logic              o_sync;
  logic              o_jam;
  logic [3:0]        o_state;

  modport master (input i_data, i_rdy, output o_ctrl, o_sync, o_jam, o_state);
  modport slave  (output i_data, i_rdy, input o_ctrl, o_sync, o_jam, o_state);
endinterface

// File: rtl/ctrl_encoder.sv
// Combinational decode of sequencer state and IR into datapath control strobes.
module ctrl_encoder
  import cpu_ctrl_pkg::*;
(
  input  state_e            i_state,
  input  logic [7:0]        i_ir,
  input  logic              i_rdy,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_sync,
  output logic              o_jam
);

  logic w_run;

  assign w_run = i_rdy || (i_state inside {StR0, StR1, StJam});

  always_comb begin
    o_ctrl = CTRL_IDLE;
    o_sync = 1'b0;
    o_jam  = (i_state == StJam);
    if (w_run) begin
      unique case (i_state)
        StV0: begin
          o_ctrl[CTRL_ZERO_ADL0] = 1'b1;
          o_ctrl[CTRL_ZERO_ADL1] = 1'b1;
          o_ctrl[CTRL_ADL_ABL]   = 1'b1;
          o_ctrl[CTRL_ADH_ABH]   = 1'b1;
        end
        StV1: begin
          o_ctrl[CTRL_ZERO_ADL1] = 1'b1;
          o_ctrl[CTRL_ADL_ABL]   = 1'b1;
        end
        StPcl: begin
          o_ctrl[CTRL_DL_ADL]  = 1'b1;
          o_ctrl[CTRL_ADL_PCL] = 1'b1;
        end
        StPch: begin
          o_ctrl[CTRL_DL_ADH]  = 1'b1;
          o_ctrl[CTRL_ADH_PCH] = 1'b1;
        end
        StFetch, StOpr, StJ0, StJ1: begin
          o_ctrl[CTRL_PCL_ADL] = 1'b1;
          o_ctrl[CTRL_PCH_ADH] = 1'b1;
          o_ctrl[CTRL_ADL_ABL] = 1'b1;
          o_ctrl[CTRL_ADH_ABH] = 1'b1;
          o_ctrl[CTRL_I_PC]    = 1'b1;
          o_ctrl[CTRL_PCL_PCL] = 1'b1;
          o_ctrl[CTRL_PCH_PCH] = 1'b1;
          o_sync = (i_state == StFetch);
        end
        StXfer: begin
          case (i_ir)
            OP_TAX:  begin o_ctrl[CTRL_AC_SB] = 1'b1; o_ctrl[CTRL_SB_X]  = 1'b1; end
            OP_TAY:  begin o_ctrl[CTRL_AC_SB] = 1'b1; o_ctrl[CTRL_SB_Y]  = 1'b1; end
            OP_TXA:  begin o_ctrl[CTRL_X_SB]  = 1'b1; o_ctrl[CTRL_SB_AC] = 1'b1; end
            OP_TYA:  begin o_ctrl[CTRL_Y_SB]  = 1'b1; o_ctrl[CTRL_SB_AC] = 1'b1; end
            default: ;
          endcase
        end
        StOprLoad: begin
          o_ctrl[CTRL_DL_DB] = 1'b1;
          o_ctrl[CTRL_SB_DB] = 1'b1;
          case (i_ir)
            OP_LDA_IMM: o_ctrl[CTRL_SB_AC] = 1'b1;
            OP_LDX_IMM: o_ctrl[CTRL_SB_X]  = 1'b1;
            OP_LDY_IMM: o_ctrl[CTRL_SB_Y]  = 1'b1;
            default:    ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU control sequencer: state register, instruction register and next-state
// logic; strobe decode lives in ctrl_encoder.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  cpu_sequencer_if.master io_bus
);

  state_e     r_state, w_state_d;
  logic [7:0] r_ir, w_ir_d;
  logic       w_hold;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StR0;
      r_ir    <= OP_NOP;
    end else begin
      r_state <= w_state_d;
      r_ir    <= w_ir_d;
    end
  end

  // Reset cycles and JAM ignore i_rdy.
  assign w_hold = !io_bus.i_rdy && !(r_state inside {StR0, StR1, StJam});

  always_comb begin
    w_state_d = r_state;
    w_ir_d    = r_ir;
    if (!w_hold) begin
      unique case (r_state)
        StR0:      w_state_d = StR1;
        StR1:      w_state_d = StV0;
        StV0:      w_state_d = StV1;
        StV1:      w_state_d = StPcl;
        StPcl:     w_state_d = StPch;
        StPch:     w_state_d = StFetch;
        StFetch:   w_state_d = StWaitOp;
        StWaitOp: begin
          w_ir_d    = io_bus.i_data;
          w_state_d = op_to_state(io_bus.i_data);
        end
        StXfer:    w_state_d = StFetch;
        StOpr:     w_state_d = StOprWait;
        StOprWait: w_state_d = StOprLoad;
        StOprLoad: w_state_d = StFetch;
        StJ0:      w_state_d = StJ1;
        StJ1:      w_state_d = StPcl;
        StJam:     w_state_d = StJam;
        default:   w_state_d = StR0;
      endcase
    end
  end

  ctrl_encoder u_ctrl_encoder (
    .i_state (r_state),
    .i_ir    (r_ir),
    .i_rdy   (io_bus.i_rdy),
    .o_ctrl  (io_bus.o_ctrl),
    .o_sync  (io_bus.o_sync),
    .o_jam   (io_bus.o_jam)
  );

  assign io_bus.o_state = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset sequence, immediate loads, transfers,
// JMP, ready stalls, JAM and asynchronous reset.
module tb_cpu_sequencer;
  import cpu_ctrl_pkg::*;

  function automatic logic [35:0] sb(input int unsigned idx);
    logic [35:0] one;
    one = 36'd1;
    return one << idx;
  endfunction

  localparam logic [35:0] W_IDLE  = sb(CTRL_RW);
  localparam logic [35:0] W_FETCH = W_IDLE | sb(CTRL_PCL_ADL) | sb(CTRL_PCH_ADH) |
                                    sb(CTRL_ADL_ABL) | sb(CTRL_ADH_ABH) | sb(CTRL_I_PC) |
                                    sb(CTRL_PCL_PCL) | sb(CTRL_PCH_PCH);
  localparam logic [35:0] W_V0    = W_IDLE | sb(CTRL_ZERO_ADL0) | sb(CTRL_ZERO_ADL1) |
                                    sb(CTRL_ADL_ABL) | sb(CTRL_ADH_ABH);
  localparam logic [35:0] W_V1    = W_IDLE | sb(CTRL_ZERO_ADL1) | sb(CTRL_ADL_ABL);
  localparam logic [35:0] W_PCL   = W_IDLE | sb(CTRL_DL_ADL) | sb(CTRL_ADL_PCL);
  localparam logic [35:0] W_PCH   = W_IDLE | sb(CTRL_DL_ADH) | sb(CTRL_ADH_PCH);
  localparam logic [35:0] W_LOAD  = W_IDLE | sb(CTRL_DL_DB) | sb(CTRL_SB_DB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  cpu_sequencer_if u_if ();

  cpu_sequencer u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [35:0] ctrl,
                            input logic sync, input logic jam);
    check($sformatf("%s.state", tag), 36'(u_if.o_state), 36'(st));
    check($sformatf("%s.ctrl", tag), u_if.o_ctrl, ctrl);
    check($sformatf("%s.sync", tag), 36'(u_if.o_sync), 36'(sync));
    check($sformatf("%s.jam", tag), 36'(u_if.o_jam), 36'(jam));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after reset deassertion; ends in the first FETCH (cycle 7).
  task automatic reset_seq(input string tag);
    u_if.i_rdy = 1'b0;
    #1;
    expect_cyc({tag, ".r0"}, StR0, W_IDLE, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".r1"}, StR1, W_IDLE, 1'b0, 1'b0);
    tick();
    u_if.i_rdy = 1'b1;
    #1;
    expect_cyc({tag, ".v0"}, StV0, W_V0, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".v1"}, StV1, W_V1, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".v2"}, StPcl, W_PCL, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".v3"}, StPch, W_PCH, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".fetch7"}, StFetch, W_FETCH, 1'b1, 1'b0);
  endtask

  task automatic op_imm(input string tag, input logic [7:0] op, input logic [35:0] load,
                        input bit stall);
    tick();
    u_if.i_data = op;
    #1;
    expect_cyc({tag, ".wait"}, StWaitOp, W_IDLE, 1'b0, 1'b0);
    tick();
    u_if.i_data = 8'h42;
    #1;
    expect_cyc({tag, ".opr"}, StOpr, W_FETCH, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".oprwait"}, StOprWait, W_IDLE, 1'b0, 1'b0);
    if (stall) begin
      u_if.i_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1;
        expect_cyc($sformatf("%s.stall%0d", tag, k), StOprWait, W_IDLE, 1'b0, 1'b0);
        tick();
      end
      u_if.i_rdy = 1'b1;
      #1;
      expect_cyc({tag, ".resume"}, StOprWait, W_IDLE, 1'b0, 1'b0);
    end
    tick();
    expect_cyc({tag, ".load"}, StOprLoad, load, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".fetch"}, StFetch, W_FETCH, 1'b1, 1'b0);
  endtask

  task automatic op_xfer(input string tag, input logic [7:0] op, input logic [35:0] word);
    tick();
    u_if.i_data = op;
    #1;
    expect_cyc({tag, ".wait"}, StWaitOp, W_IDLE, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".xfer"}, StXfer, word, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".fetch"}, StFetch, W_FETCH, 1'b1, 1'b0);
  endtask

  // Runs JMP up to J2; the caller decides whether to finish or reset there.
  task automatic jmp_to_j2(input string tag);
    tick();
    u_if.i_data = OP_JMP_ABS;
    #1;
    expect_cyc({tag, ".wait"}, StWaitOp, W_IDLE, 1'b0, 1'b0);
    tick();
    u_if.i_data = 8'h34;
    #1;
    expect_cyc({tag, ".j0"}, StJ0, W_FETCH, 1'b0, 1'b0);
    tick();
    u_if.i_data = 8'h12;
    #1;
    expect_cyc({tag, ".j1"}, StJ1, W_FETCH, 1'b0, 1'b0);
    tick();
    expect_cyc({tag, ".j2"}, StPcl, W_PCL, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  xfer_op[4];
    logic [35:0] xfer_w[4];
    xfer_op = '{OP_TAX, OP_TAY, OP_TXA, OP_TYA};
    xfer_w  = '{W_IDLE | sb(CTRL_AC_SB) | sb(CTRL_SB_X),
                W_IDLE | sb(CTRL_AC_SB) | sb(CTRL_SB_Y),
                W_IDLE | sb(CTRL_X_SB)  | sb(CTRL_SB_AC),
                W_IDLE | sb(CTRL_Y_SB)  | sb(CTRL_SB_AC)};

    u_if.i_data = 8'h00;
    u_if.i_rdy  = 1'b1;
    rst         = 1'b1;
    tick();
    tick();
    expect_cyc("rst", StR0, W_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    reset_seq("boot");

    // FETCH frozen by i_rdy=0 drops to the idle word without sync.
    u_if.i_rdy = 1'b0;
    #1;
    expect_cyc("fetch_rdy0", StFetch, W_IDLE, 1'b0, 1'b0);
    u_if.i_rdy = 1'b1;
    #1;

    op_imm("lda", OP_LDA_IMM, W_LOAD | sb(CTRL_SB_AC), 1'b0);
    op_imm("ldx", OP_LDX_IMM, W_LOAD | sb(CTRL_SB_X), 1'b1);
    op_imm("ldy", OP_LDY_IMM, W_LOAD | sb(CTRL_SB_Y), 1'b0);
    for (int i = 0; i < 4; i++) op_xfer($sformatf("xfer%0d", i), xfer_op[i], xfer_w[i]);

    // NOP goes straight back to FETCH.
    tick();
    u_if.i_data = OP_NOP;
    #1;
    expect_cyc("nop.wait", StWaitOp, W_IDLE, 1'b0, 1'b0);
    tick();
    expect_cyc("nop.fetch", StFetch, W_FETCH, 1'b1, 1'b0);

    jmp_to_j2("jmp");
    tick();
    expect_cyc("jmp.j3", StPch, W_PCH, 1'b0, 1'b0);
    tick();
    expect_cyc("jmp.fetch", StFetch, W_FETCH, 1'b1, 1'b0);

    // Asynchronous reset in the middle of J2.
    jmp_to_j2("jmpr");
    #2;
    rst = 1'b1;
    #1;
    expect_cyc("jmpr.async", StR0, W_IDLE, 1'b0, 1'b0);
    tick();
    expect_cyc("jmpr.held", StR0, W_IDLE, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    reset_seq("reboot");

    // Unsupported opcode jams for good, regardless of i_rdy.
    tick();
    u_if.i_data = 8'h02;
    #1;
    expect_cyc("jam.wait", StWaitOp, W_IDLE, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      u_if.i_rdy = (k >= 10) ? 1'b0 : 1'b1;
      #1;
      expect_cyc($sformatf("jam%0d", k), StJam, W_IDLE, 1'b0, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    expect_cyc("jam.reset", StR0, W_IDLE, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    u_if.i_rdy = 1'b1;
    tick();
    expect_cyc("jam.restart", StR1, W_IDLE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
